seq_shift_mult: RTL and testbench

//   Parametrised sequential unsigned multiplier using shift-and-add, one partial product per clock.

---
 rtl/seq_shift_mult.sv | 56 +++++
 tb/tb_seq_shift_mult.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_mult.sv
// seq_shift_mult: WIDTH x WIDTH unsigned shift-and-add multiplier, one partial product per clock
module seq_shift_mult #(
   parameter int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [2*WIDTH-1:0] mcand, acc, sum;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] count;
   always_comb sum = mplier[0] ? acc + mcand : acc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               mcand  <= {{WIDTH{1'b0}}, a};
               mplier <= b;
               acc    <= '0;
               count  <= '0;
               busy   <= 1'b1;
               state  <= RUN;
            end
         end else begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
               product <= sum;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_shift_mult.sv
// tb_seq_shift_mult: directed and table-driven checks of seq_shift_mult at WIDTH=4 and WIDTH=8
module tb_seq_shift_mult;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start4 = 1'b0, start8 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [7:0] product4;
   logic [15:0] product8;
   logic busy4, done4, busy8, done8;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_shift_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
                                     .product(product4), .busy(busy4), .done(done4));
   seq_shift_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
                                     .product(product8), .busy(busy8), .done(done8));

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec4_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec8_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p, output int lat);
      @(negedge clk);
      a4 = a; b4 = b; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("busy4_after_accept", busy4, 1);
      lat = 0;
      while (!done4 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      p = product4;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, output logic [15:0] p, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      p = product8;
   endtask

   initial begin
      vec4_t v4 [8];
      vec8_t v8 [4];
      vec4_t bb [3];
      logic [7:0] p4;
      logic [15:0] p8;
      int lat, n;
      v4[0] = '{4'd1, 4'd2, 8'd2};
      v4[1] = '{4'd15, 4'd15, 8'd225};
      v4[2] = '{4'd0, 4'd9, 8'd0};
      v4[3] = '{4'd9, 4'd0, 8'd0};
      v4[4] = '{4'd3, 4'd5, 8'd15};
      v4[5] = '{4'd12, 4'd11, 8'd132};
      v4[6] = '{4'd7, 4'd8, 8'd56};
      v4[7] = '{4'd10, 4'd13, 8'd130};
      v8[0] = '{8'd255, 8'd255, 16'd65025};
      v8[1] = '{8'd0, 8'd200, 16'd0};
      v8[2] = '{8'd128, 8'd2, 16'd256};
      v8[3] = '{8'd17, 8'd15, 16'd255};
      bb[0] = '{4'd2, 4'd3, 8'd6};
      bb[1] = '{4'd5, 4'd5, 8'd25};
      bb[2] = '{4'd15, 4'd1, 8'd15};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_product4", product4, 0);
      chk("reset_busy4", busy4, 0);
      chk("reset_done4", done4, 0);
      chk("reset_product8", product8, 0);
      chk("reset_busy8", busy8, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         op4(v4[i].a, v4[i].b, p4, lat);
         chk("vec4_product", p4, v4[i].p);
         chk("vec4_latency", lat, 4);
         chk("vec4_busy_at_done", busy4, 0);
         @(posedge clk); #1;
         chk("vec4_done_one_cycle", done4, 0);
         chk("vec4_product_hold", product4, v4[i].p);
      end

      // start during RUN must be dropped, not queued
      @(negedge clk);
      a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 2;
      while (!done4 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("ignore_product", product4, 15);
      chk("ignore_latency", lat, 4);
      @(posedge clk); #1;
      chk("ignore_no_requeue", busy4, 0);

      @(negedge clk);
      a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_product", product4, 0);
      chk("async_rst_busy", busy4, 0);
      chk("async_rst_done", done4, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done4 || busy4) n++;
      end
      chk("no_stale_done", n, 0);
      chk("rst_product_held", product4, 0);

      @(negedge clk);
      a4 = bb[0].a; b4 = bb[0].b; start4 = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) begin
            a4 = bb[i+1].a; b4 = bb[i+1].b;
         end
         n = 0;
         while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk("b2b_latency", n, 4);
         chk("b2b_product", product4, bb[i].p);
         if (i == 2) start4 = 1'b0;
         @(posedge clk); #1;
         chk("b2b_busy_next", busy4, (i < 2) ? 1 : 0);
         chk("b2b_done_cleared", done4, 0);
      end

      for (int i = 0; i < 4; i++) begin
         op8(v8[i].a, v8[i].b, p8, lat);
         chk("vec8_product", p8, v8[i].p);
         chk("vec8_latency", lat, 8);
      end

      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            op4(4'(x), 4'(y), p4, lat);
            chk("sweep_product", p4, x * y);
            chk("sweep_latency", lat, 4);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
